cntr_bs_arb: RTL and testbench

//  Bank arbiter on the responder side of the bank-scheduler valid/ready interface.

---
 rtl/cntr_pkg.sv | 28 ++
 rtl/cntr_arb_fifo.sv | 57 +++++
 rtl/cntr_bs_arb.sv | 131 +++++++++++++
 tb/tb_cntr_bs_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_pkg.sv
// Shared types for the bank-scheduler arbiter: request word, arbiter state and buffered entry.
package cntr_pkg;

  localparam int CNTR_BANKS     = 16;
  localparam int CNTR_REQ_W     = 32;
  localparam int CNTR_OUT_DEPTH = 4;
  localparam int CNTR_MAX_BEATS = 16;
  localparam int CNTR_BANK_W    = $clog2(CNTR_BANKS);

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef logic [CNTR_REQ_W-1:0] req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [CNTR_BANK_W-1:0] bank;
    logic                   first;
    req_t                   req;
  } arb_entry_t;

endpackage

// File: rtl/cntr_arb_fifo.sv
// Synchronous FIFO of arbiter entries; head is always presented, occupancy exported as a count.
module cntr_arb_fifo
  import cntr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  arb_entry_t               i_data,
  input  logic                     i_pop,
  output arb_entry_t               o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  arb_entry_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  // Push is refused when full even if a pop lands in the same cycle (no bypass).
  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/cntr_bs_arb.sv
// Round-robin bank arbiter: grants one scheduler at a time and queues its burst toward the command path.
//   state | meaning
//   IDLE  | no grant; pick next valid bank at/after rr_ptr
//   GRANT | bank cur owns ready_o until burst end or beat cap
module cntr_bs_arb
  import cntr_pkg::*;
#(
  parameter int BANKS     = CNTR_BANKS,
  parameter int REQ_W     = CNTR_REQ_W,
  parameter int OUT_DEPTH = CNTR_OUT_DEPTH,
  parameter int MAX_BEATS = CNTR_MAX_BEATS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [BANKS-1:0]             valid_i,
  input  logic [BANKS-1:0][REQ_W-1:0]  req_i,
  output logic [BANKS-1:0]             ready_o,
  output logic                         out_valid,
  output logic [REQ_W-1:0]             out_req,
  output logic [$clog2(BANKS)-1:0]     out_bank,
  output logic                         out_first,
  input  logic                         out_ready
);

  localparam int BW  = $clog2(BANKS);
  localparam int BCW = $clog2(MAX_BEATS);
  localparam int CW  = $clog2(OUT_DEPTH) + 1;

  arb_state_e     r_state;
  logic [BW-1:0]  r_cur;
  logic [BW-1:0]  r_rr_ptr;
  logic [BCW-1:0] r_beat_cnt;

  logic [CW-1:0]  w_count;
  logic           w_full;
  logic           w_beat;
  logic           w_pop;
  logic           w_cap;
  arb_entry_t     w_push_entry;
  arb_entry_t     w_head;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  function automatic logic [BW-1:0] rr_pick(input logic [BANKS-1:0] v, input logic [BW-1:0] ptr);
    logic [2*BANKS-1:0] w_dbl;
    logic [BANKS-1:0]   w_rot;
    logic [BW-1:0]      w_off;
    logic [BW:0]        w_sum;
    w_dbl = {v, v} >> ptr;
    w_rot = w_dbl[BANKS-1:0];
    w_off = '0;
    for (int i = BANKS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = BW'(i);
    end
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= (BW+1)'(BANKS)) w_sum = w_sum - (BW+1)'(BANKS);
    return w_sum[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == BW'(BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  assign w_full = (w_count == CW'(OUT_DEPTH));
  assign w_beat = (r_state == GRANT) && valid_i[r_cur] && !w_full;
  assign w_cap  = (r_beat_cnt == BCW'(MAX_BEATS - 1));
  assign w_pop  = out_valid && out_ready;

  // ready_o depends only on registered state so schedulers see no comb path from valid_i.
  always_comb begin
    ready_o = '0;
    if ((r_state == GRANT) && !w_full) ready_o[r_cur] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|valid_i) begin
            r_cur      <= rr_pick(valid_i, r_rr_ptr);
            r_beat_cnt <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (!valid_i[r_cur]) begin
            r_state  <= IDLE;
            r_rr_ptr <= next_bank(r_cur);
          end else if (w_beat) begin
            if (w_cap) begin
              r_state  <= IDLE;
              r_rr_ptr <= next_bank(r_cur);
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.bank  = r_cur;
    w_push_entry.first = (r_beat_cnt == '0);
    w_push_entry.req   = req_i[r_cur];
  end

  cntr_arb_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_beat),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign out_valid = (w_count != '0);
  assign out_req   = w_head.req;
  assign out_bank  = w_head.bank;
  assign out_first = w_head.first;

endmodule

// File: tb/tb_cntr_bs_arb.sv
// Directed bench for cntr_bs_arb: bank drivers honour ready_o, expected beats are queued and checked at pop.
module tb_cntr_bs_arb;
  import cntr_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       valid_i;
  logic [15:0][31:0] req_i;
  logic [15:0]       ready_o;
  logic              out_valid;
  logic [31:0]       out_req;
  logic [3:0]        out_bank;
  logic              out_first;
  logic              out_ready;

  always #5 clk = ~clk;

  cntr_bs_arb #(
    .BANKS     (16),
    .REQ_W     (32),
    .OUT_DEPTH (4),
    .MAX_BEATS (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .req_i     (req_i),
    .ready_o   (ready_o),
    .out_valid (out_valid),
    .out_req   (out_req),
    .out_bank  (out_bank),
    .out_first (out_first),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [3:0]  bank;
    logic        first;
    logic [31:0] req;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          left[16];
  int          seq[16];
  int          acc[16];
  logic [15:0] t2_tr[8];

  function automatic logic [31:0] mkreq(int b, int s);
    return 32'hA500_0000 | (32'(b) << 16) | (32'(s) & 32'h0000_FFFF);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int b = 0; b < 16; b++) begin
      valid_i[b] = (left[b] > 0);
      req_i[b]   = mkreq(b, seq[b]);
    end
  endtask

  task automatic clear_banks();
    for (int b = 0; b < 16; b++) begin
      left[b] = 0;
      seq[b]  = 0;
      acc[b]  = 0;
    end
    q.delete();
    drive();
  endtask

  task automatic push_exp(int b, int s0, int n);
    for (int k = 0; k < n; k++) begin
      q.push_back('{bank: 4'(b), first: (k == 0), req: mkreq(b, s0 + k)});
    end
  endtask

  // Called at posedge+1: samples handshakes that the next edge will see, then applies scheduler updates.
  task automatic tick();
    logic [15:0] hs;
    exp_t        e;
    hs = valid_i & ready_o;
    if (out_valid && out_ready) begin
      tests++;
      assert (q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_pop: observed bank %0d req 0x%0h, expected no output", out_bank, out_req);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_bank", 32'(out_bank), 32'(e.bank));
        chk("out_first", 32'(out_first), 32'(e.first));
        chk("out_req", out_req, e.req);
      end
    end
    @(posedge clk);
    #1;
    for (int b = 0; b < 16; b++) begin
      if (hs[b]) begin
        left[b]--;
        seq[b]++;
        acc[b]++;
      end
    end
    drive();
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while ((q.size() > 0 || valid_i != '0) && n < budget) begin
      tick();
      n++;
    end
    tests++;
    assert (q.size() == 0 && valid_i == '0) else begin
      fails++;
      $error("FAIL %s_drain: observed %0d entries pending, expected 0", tag, q.size());
    end
  endtask

  task automatic wait_acc(string tag, int b, int n, int budget);
    int k;
    k = 0;
    while (acc[b] < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(acc[b]), 32'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_banks();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    t2_tr = '{16'h0000, 16'h0002, 16'h0002, 16'h0002, 16'h0002, 16'h0000, 16'h0020, 16'h0020};
    out_ready = 1'b0;
    rst_n     = 1'b0;
    clear_banks();
    #1;
    chk("rst_ready_o", 32'(ready_o), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_req", out_req, 32'h0);
    chk("rst_out_bank", 32'(out_bank), 32'h0);
    chk("rst_out_first", 32'(out_first), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single bank burst
    out_ready = 1'b1;
    left[2] = 3;
    drive();
    push_exp(2, 0, 3);
    chk("t1_ready_idle", 32'(ready_o), 32'h0);
    tick();
    chk("t1_ready_grant", 32'(ready_o), 32'h0004);
    drain("t1", 40);

    // 2: two banks from rr_ptr=0, one IDLE bubble between grants
    do_reset();
    out_ready = 1'b1;
    left[1] = 3;
    left[5] = 2;
    drive();
    push_exp(1, 0, 3);
    push_exp(5, 0, 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_ready_%0d", i), 32'(ready_o), 32'(t2_tr[i]));
      tick();
    end
    drain("t2", 40);

    // 3: fairness cap
    left[0] = 20;
    left[3] = 16;
    drive();
    push_exp(0, 0, 16);
    push_exp(3, 0, 16);
    push_exp(0, 16, 4);
    wait_acc("t3_acc0_cap", 0, 16, 100);
    chk("t3_release_ready", 32'(ready_o), 32'h0);
    chk("t3_acc3_before", 32'(acc[3]), 32'h0);
    tick();
    chk("t3_next_grant", 32'(ready_o), 32'h0008);
    drain("t3", 200);

    // 4: backpressure fills the buffer, one pop admits exactly one beat
    out_ready = 1'b0;
    left[7] = 10;
    drive();
    push_exp(7, 0, 10);
    repeat (10) tick();
    chk("t4_acc_full", 32'(acc[7]), 32'd4);
    chk("t4_ready_full", 32'(ready_o), 32'h0);
    chk("t4_out_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (5) tick();
    chk("t4_acc_after_pop", 32'(acc[7]), 32'd5);
    chk("t4_ready_refull", 32'(ready_o), 32'h0);
    out_ready = 1'b1;
    drain("t4", 100);

    // 5: reset mid-grant with two entries buffered
    out_ready = 1'b0;
    left[9] = 5;
    drive();
    push_exp(9, 0, 2);
    wait_acc("t5_acc_two", 9, 2, 20);
    chk("t5_out_valid_pre", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready_o", 32'(ready_o), 32'h0);
    chk("t5_rst_out_valid", 32'(out_valid), 32'h0);
    chk("t5_rst_out_bank", 32'(out_bank), 32'h0);
    chk("t5_rst_out_req", out_req, 32'h0);
    clear_banks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t5_post_out_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    left[4] = 1;
    drive();
    push_exp(4, 0, 1);
    drain("t5", 40);

    // 6: bank 15 wraps rr_ptr to 0, so bank 0 beats bank 14
    left[15] = 1;
    drive();
    push_exp(15, 0, 1);
    wait_acc("t6_acc15", 15, 1, 20);
    left[0]  = 2;
    left[14] = 2;
    drive();
    push_exp(0, seq[0], 2);
    push_exp(14, seq[14], 2);
    tick();
    tick();
    chk("t6_grant_bank0", 32'(ready_o), 32'h0001);
    drain("t6", 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
